// File: rtl/split_adder_arbiter.sv
// -----------------------------------------------------------------------------
// split_adder_arbiter
//
// Shares one free-running 3-phase split adder (ADD0 -> ADD1 -> SEL) among
// NREQ requesters. The block picks a requester and latches its operands. It
// then resynchronises the adder phase through its reset and holds the adder
// inputs stable. Finally it returns the registered sum, carry-out and owner id
// over a valid/ready port.
//
// Build option:
//   ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest asserted index wins
//                      undefined -> round-robin starting after the last grant
//
// Ports:
//   clock          in   rising-edge clock
//   reset          in   asynchronous active-low reset
//   req_valid      in   [NREQ]      per-requester request, held until req_ack
//   req_a, req_b   in   [NREQ*IO]   operands, requester i at [i*IO +: IO]
//   req_cin        in   [NREQ]      per-requester carry-in
//   req_ack        out  [NREQ]      one-hot single-cycle acceptance pulse
//   resp_valid     out              result available
//   resp_ready     in               consumer accepts result
//   resp_id        out  [IDW]       owner of the result
//   resp_sum       out  [IO]        registered sum
//   resp_overflow  out              registered carry-out
//   add_rst        out              sync active-high reset to the adder
//   add_a, add_b   out  [IO]        adder operands, stable for the whole op
//   add_cin        out              adder carry-in
//   add_sum        in   [IO]        adder registered sum
//   add_overflow   in               adder registered carry-out
// -----------------------------------------------------------------------------
module split_adder_arbiter #(
    parameter  int IO   = 512,
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*IO-1:0]   req_a,
    input  logic [NREQ*IO-1:0]   req_b,
    input  logic [NREQ-1:0]      req_cin,
    output logic [NREQ-1:0]      req_ack,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [IO-1:0]        resp_sum,
    output logic                 resp_overflow,
    output logic                 add_rst,
    output logic [IO-1:0]        add_a,
    output logic [IO-1:0]        add_b,
    output logic                 add_cin,
    input  logic [IO-1:0]        add_sum,
    input  logic                 add_overflow
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        A0   = 3'd2,
        A1   = 3'd3,
        SEL  = 3'd4,
        CAP  = 3'd5,
        RESP = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] req_ack_q, req_ack_d;
    logic            resp_valid_q, resp_valid_d;
    logic [IDW-1:0]  resp_id_q, resp_id_d;
    logic [IO-1:0]   resp_sum_q, resp_sum_d;
    logic            resp_ovf_q, resp_ovf_d;
    logic            add_rst_q, add_rst_d;
    logic [IO-1:0]   add_a_q, add_a_d;
    logic [IO-1:0]   add_b_q, add_b_d;
    logic            add_cin_q, add_cin_d;
`ifndef ARB_FIXED_PRIO_EN
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
`endif

    logic            gnt_found_s;
    logic [IDW-1:0]  gnt_idx_s;
    logic [IDW-1:0]  cand_s;
    logic [IO-1:0]   sel_a_s;
    logic [IO-1:0]   sel_b_s;
    logic            sel_cin_s;

    // Arbitration and operand mux for the winning requester.
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_idx_s   = '0;
        cand_s      = '0;
        sel_a_s     = '0;
        sel_b_s     = '0;
        sel_cin_s   = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
        // Scan high to low so the lowest asserted index is the last writer.
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand_s = IDW'(k);
            if (req_valid[cand_s]) begin
                gnt_found_s = 1'b1;
                gnt_idx_s   = cand_s;
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
`else
        // Scan offsets NREQ..1 after rr_ptr so the nearest one wins.
        for (int k = NREQ; k >= 1; k--) begin
            cand_s = IDW'((int'(rr_ptr_q) + k) % NREQ);
            if (req_valid[cand_s]) begin
                gnt_found_s = 1'b1;
                gnt_idx_s   = cand_s;
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
`endif
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_idx_s == IDW'(k)) begin
                sel_a_s   = req_a[k*IO +: IO];
                sel_b_s   = req_b[k*IO +: IO];
                sel_cin_s = req_cin[k];
            end else begin
                sel_cin_s = sel_cin_s;
            end
        end
    end

    // Next-state and registered-output computation for the operation FSM.
    always_comb begin
        state_d      = state_q;
        req_ack_d    = '0;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_sum_d   = resp_sum_q;
        resp_ovf_d   = resp_ovf_q;
        add_rst_d    = add_rst_q;
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;
        add_cin_d    = add_cin_q;
`ifndef ARB_FIXED_PRIO_EN
        rr_ptr_d     = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                // add_rst stays high through SYNC so the adder lands in ADD0 at A0.
                add_rst_d = 1'b1;
                if (gnt_found_s) begin
                    add_a_d   = sel_a_s;
                    add_b_d   = sel_b_s;
                    add_cin_d = sel_cin_s;
                    resp_id_d = gnt_idx_s;
                    req_ack_d = {{(NREQ-1){1'b0}}, 1'b1} << gnt_idx_s;
`ifndef ARB_FIXED_PRIO_EN
                    rr_ptr_d  = gnt_idx_s;
`endif
                    state_d   = SYNC;
                end else begin
                    state_d   = IDLE;
                end
            end
            SYNC: begin
                add_rst_d = 1'b0;
                state_d   = A0;
            end
            A0: begin
                add_rst_d = 1'b0;
                state_d   = A1;
            end
            A1: begin
                state_d = SEL;
            end
            SEL: begin
                state_d = CAP;
            end
            CAP: begin
                resp_sum_d   = add_sum;
                resp_ovf_d   = add_overflow;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    add_rst_d    = 1'b1;
                    state_d      = IDLE;
                end else begin
                    state_d      = RESP;
                end
            end
            default: begin
                resp_valid_d = 1'b0;
                add_rst_d    = 1'b1;
                state_d      = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            req_ack_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_sum_q   <= '0;
            resp_ovf_q   <= 1'b0;
            add_rst_q    <= 1'b1;
            add_a_q      <= '0;
            add_b_q      <= '0;
            add_cin_q    <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr_q     <= IDW'(NREQ - 1);
`endif
        end else begin
            state_q      <= state_d;
            req_ack_q    <= req_ack_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_sum_q   <= resp_sum_d;
            resp_ovf_q   <= resp_ovf_d;
            add_rst_q    <= add_rst_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            add_cin_q    <= add_cin_d;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr_q     <= rr_ptr_d;
`endif
        end
    end

    assign req_ack       = req_ack_q;
    assign resp_valid    = resp_valid_q;
    assign resp_id       = resp_id_q;
    assign resp_sum      = resp_sum_q;
    assign resp_overflow = resp_ovf_q;
    assign add_rst       = add_rst_q;
    assign add_a         = add_a_q;
    assign add_b         = add_b_q;
    assign add_cin       = add_cin_q;

endmodule
